// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the requester handshake, FIFO write port and
// debug outputs of the write-port arbiter.
//   master : requester/FIFO side (drives arb_en, src_valid, src_data, fifo_full)
//   slave  : arbiter side (drives src_ready, wr_req, data_in, grant, busy, src_cnt)
interface fifo_wr_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
);
    logic                      arb_en;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      fifo_full;
    logic                      wr_req;
    logic [DATA_W-1:0]         data_in;
    logic [NUM_SRC-1:0]        grant;
    logic                      busy;
    logic [NUM_SRC*CNT_W-1:0]  src_cnt;

    modport master (
        output arb_en, src_valid, src_data, fifo_full,
        input  src_ready, wr_req, data_in, grant, busy, src_cnt
    );

    modport slave (
        input  arb_en, src_valid, src_data, fifo_full,
        output src_ready, wr_req, data_in, grant, busy, src_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_SRC valid/ready requesters. One source is granted at a time for a burst
// of up to MAX_BURST words; writes stall while fifo_full is high.
// Ports:
//   w_clk - write-domain clock
//   wrst  - synchronous active-high reset
//   bus   - fifo_wr_arbiter_if.slave (handshakes, FIFO write port, debug)

// Per-source lane: accept gating and accepted-word counter.
module fifo_wr_arbiter_lane #(
    parameter int CNT_W = 16
) (
    input  logic             w_clk,
    input  logic             wrst,
    input  logic             gnt,
    input  logic             valid,
    input  logic             full,
    output logic             ready,
    output logic             fire,
    output logic [CNT_W-1:0] cnt
);
    assign ready = gnt & ~full;
    assign fire  = valid & ready;

    always_ff @(posedge w_clk) begin
        if (wrst)
            cnt <= '0;
        else if (fire)
            cnt <= cnt + 1'b1;
    end
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic               w_clk,
    input  logic               wrst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                        state_q, state_n;
    logic [NUM_SRC-1:0]            grant_q, grant_n;
    logic [IDX_W-1:0]              last_q, last_n;
    logic [BEAT_W-1:0]             beat_q, beat_n;

    logic [NUM_SRC-1:0]            ready_w;
    logic [NUM_SRC-1:0]            fire_w;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_w;

    logic                          xfer;
    logic                          gnt_valid;
    logic                          pick_found;
    logic [IDX_W-1:0]              pick_idx;
    logic [IDX_W:0]                cand;
    logic [DATA_W-1:0]             data_mux;

    // Lanes see grant_q directly; grant_q is zero outside BURST, so no
    // source can be accepted while arbitrating.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        fifo_wr_arbiter_lane #(.CNT_W(CNT_W)) u_lane (
            .w_clk (w_clk),
            .wrst  (wrst),
            .gnt   (grant_q[g]),
            .valid (bus.src_valid[g]),
            .full  (bus.fifo_full),
            .ready (ready_w[g]),
            .fire  (fire_w[g]),
            .cnt   (cnt_w[g])
        );
    end

    assign xfer      = |fire_w;
    assign gnt_valid = |(bus.src_valid & grant_q);

    // Round-robin scan starting one past the last grant. Sum stays below
    // 2*NUM_SRC, so a single conditional subtract implements the modulo.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SRC))
                cand = cand - (IDX_W+1)'(NUM_SRC);
            if (!pick_found && bus.src_valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // AND-OR mux on the one-hot grant: reads as zero with no grant, so
    // data_in is never X once reset has cleared grant_q.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (grant_q[i])
                data_mux = data_mux | bus.src_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            last_q  <= last_n;
            beat_q  <= beat_n;
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        last_n  = last_q;
        beat_n  = beat_q;
        case (state_q)
            IDLE: begin
                if (bus.arb_en && pick_found) begin
                    grant_n = NUM_SRC'(1) << pick_idx;
                    last_n  = pick_idx;
                    beat_n  = '0;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
                        grant_n = '0;
                        state_n = IDLE;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end else if (!gnt_valid) begin
                    // Source dropped valid: forfeit the rest of the burst.
                    grant_n = '0;
                    state_n = IDLE;
                end
                // Otherwise fifo_full stall: hold grant and beat count.
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    assign bus.src_ready = ready_w;
    assign bus.wr_req    = xfer;
    assign bus.data_in   = data_mux;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.src_cnt   = cnt_w;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level round-robin model.
// Counter width is reduced so the wrap case is reachable in a short run.
module tb_fifo_wr_arbiter;
    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 8;

    logic w_clk = 1'b0;
    logic wrst;
    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .w_clk (w_clk),
        .wrst  (wrst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the port (-1 = nobody), words moved in this burst,
    // last source granted, and words accepted per source.
    int m_owner, m_beats, m_last;
    int m_cnt [NUM_SRC];
    bit m_xfer;
    int m_xsrc;
    int wr_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = NUM_SRC - 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int i);
        return bus.src_cnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        bus.src_data[i*DATA_W +: DATA_W] = v;
    endtask

    // Called at posedge+1 with this cycle's inputs already applied.
    task automatic step();
        logic [NUM_SRC-1:0] eg, er;
        bit ew;
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ew = (m_owner >= 0) ? (bus.src_valid[m_owner] && !bus.fifo_full) : 1'b0;
        er = (m_owner >= 0 && !bus.fifo_full) ? eg : '0;
        chk("grant", bus.grant, eg);
        chk("src_ready", bus.src_ready, er);
        chk("wr_req", bus.wr_req, ew);
        chk("busy", bus.busy, m_owner >= 0);
        chk("data_known", $isunknown(bus.data_in), 0);
        if (ew)
            chk("data_in", bus.data_in, bus.src_data[m_owner*DATA_W +: DATA_W]);
        for (int i = 0; i < NUM_SRC; i++)
            chk($sformatf("src_cnt%0d", i), cnt_of(i), m_cnt[i]);
        if (bus.wr_req === 1'b1) wr_seen++;
        m_xfer = ew;
        m_xsrc = m_owner;
        if (wrst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (bus.arb_en)
                for (int k = 1; k <= NUM_SRC; k++) begin
                    int c;
                    c = (m_last + k) % NUM_SRC;
                    if (bus.src_valid[c]) begin
                        m_owner = c;
                        m_last  = c;
                        m_beats = 0;
                        break;
                    end
                end
        end else if (ew) begin
            m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CNT_W);
            m_beats++;
            if (m_beats == MAX_BURST) m_owner = -1;
        end else if (!bus.src_valid[m_owner]) begin
            m_owner = -1;
        end
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        wrst = 1'b1;
        repeat (n) step();
        wrst = 1'b0;
    endtask

    initial begin
        int k, w1, stall_left, stall_obs;
        wrst          = 1'b1;
        bus.arb_en    = 1'b1;
        bus.src_valid = '1;
        bus.src_data  = '0;
        bus.fifo_full = 1'b0;
        wr_seen       = 0;
        model_reset();
        for (int i = 0; i < NUM_SRC; i++) set_data(i, $urandom);
        @(posedge w_clk);
        #1;

        // 1: reset with every source requesting, then first grant -> source 0
        do_reset(2);
        step();
        chk("t1_first_grant", bus.grant, 4'b0001);

        // 2: source 2 alone, six words across two bursts
        bus.src_valid = '0;
        do_reset(1);
        bus.src_valid = 4'b0100;
        set_data(2, 32'hA0);
        k = 0; wr_seen = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            step();
            if (m_xfer) begin
                k++;
                set_data(2, 32'hA0 + k);
                if (k == 6) bus.src_valid = '0;
            end
        end
        chk("t2_words", wr_seen, 6);
        chk("t2_cnt2", cnt_of(2), 6);

        // 3: all sources continuously requesting for 40 cycles
        do_reset(1);
        bus.src_valid = '1;
        wr_seen = 0;
        repeat (40) begin
            step();
            if (m_xfer) set_data(m_xsrc, $urandom);
        end
        chk("t3_words", wr_seen, 32);
        for (int i = 0; i < NUM_SRC; i++) chk($sformatf("t3_cnt%0d", i), cnt_of(i), 8);

        // 4: three-cycle full stall after the second word of a burst
        bus.src_valid = '0;
        do_reset(1);
        bus.src_valid = 4'b0001;
        k = 0; stall_left = 3; stall_obs = 0; wr_seen = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (k == 2 && stall_left > 0) begin
                bus.fifo_full = 1'b1;
                stall_left--;
            end else begin
                bus.fifo_full = 1'b0;
            end
            step();
            if (bus.fifo_full && bus.grant == 4'b0001 && !bus.wr_req) stall_obs++;
            if (m_xfer) begin
                k++;
                set_data(0, $urandom);
            end
        end
        bus.fifo_full = 1'b0;
        bus.src_valid = '0;
        chk("t4_burst", wr_seen, 4);
        chk("t4_stall", stall_obs, 3);

        // 5: source 1 drops valid after 2 words; source 3 is next
        do_reset(1);
        bus.src_valid = 4'b1010;
        w1 = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (m_xfer && m_xsrc == 1) begin
                w1++;
                set_data(1, $urandom);
                if (w1 == 2) bus.src_valid[1] = 1'b0;
            end
            if (bus.grant == 4'b1000) break;
        end
        chk("t5_next_grant", bus.grant, 4'b1000);
        bus.arb_en = 1'b0;
        repeat (12) begin
            step();
            if (m_xfer) set_data(m_xsrc, $urandom);
        end
        chk("t5_idle_grant", bus.grant, 0);
        chk("t5_cnt3", cnt_of(3), 4);
        bus.arb_en = 1'b1;
        step();
        chk("t5_regrant", bus.grant, 4'b1000);

        // 6a: reset during the second beat of a burst
        bus.src_valid = '1;
        do_reset(1);
        k = 0;
        for (int c = 0; c < 10 && k < 1; c++) begin
            step();
            if (m_xfer) k++;
        end
        wrst = 1'b1;
        step();
        wrst = 1'b0;
        chk("t6_rst_grant", bus.grant, 0);
        chk("t6_rst_cnt0", cnt_of(0), 0);
        step();
        chk("t6_post_grant", bus.grant, 4'b0001);

        // 6b: counter wrap after 2^CNT_W words from one source
        bus.src_valid = '0;
        do_reset(1);
        bus.src_valid = 4'b0001;
        wr_seen = 0;
        for (int c = 0; c < 400 && wr_seen < (1 << CNT_W); c++) begin
            step();
            if (m_xfer) set_data(0, $urandom);
        end
        bus.src_valid = '0;
        chk("t6_wrap_words", wr_seen, 1 << CNT_W);
        chk("t6_wrap_cnt", cnt_of(0), 0);

        // Randomized traffic; sources hold data until accepted, may drop valid
        do_reset(1);
        repeat (3000) begin
            bus.fifo_full = ($urandom_range(0, 4) == 0);
            bus.arb_en    = ($urandom_range(0, 9) != 0);
            wrst          = ($urandom_range(0, 299) == 0);
            step();
            for (int i = 0; i < NUM_SRC; i++) begin
                if (m_xfer && m_xsrc == i) begin
                    bus.src_valid[i] = ($urandom_range(0, 3) != 0);
                    set_data(i, $urandom);
                end else if (bus.src_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.src_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.src_valid[i] = 1'b1;
                    set_data(i, $urandom);
                end
            end
        end
        wrst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
